keypad_scanner: RTL
===================

Name: keypad_scanner

Overview:
- Front-end stage of the digital lock. Scans a 4x4 active-low matrix keypad, debounces it, and presents one 4-bit key code plus a held-key level, bstate.
- bstate and button feed the code-validity stage directly. That stage latches each digit on the falling edge of bstate, so a clean, glitch-free bstate release edge is the primary deliverable.

Parameters:
- SCAN_DIV, 12000: hwclk cycles each column is driven (dwell). Legal range is 3 or more.
- DEBOUNCE_SCANS, 4: consecutive identical full-scan frames required to accept a press, and consecutive empty frames required to accept a release. Legal range is 1 to 15.

Ports:
- hwclk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- row_in  input  4  keypad rows. Active-low, externally pulled up, asynchronous.
- col_out  output  4  keypad column drive. Exactly one bit is low (the active column); the others are high.
- button  output  4  code of the last accepted key. It holds its value after release.
- bstate  output  1  high while the debounced key is held. Its falling edge marks the end of a keystroke.
- key_strobe  output  1  one-cycle pulse in the cycle bstate rises.
- multi  output  1  high for one frame-evaluation cycle when a frame saw more than one key.

Behaviour:
- Reset (any cycle, including mid-scan or mid-debounce):
  - Outputs: col_out=4'b1110, button=0, bstate=0, key_strobe=0, multi=0.
  - Internal state: column index=0, dwell counter=0, press/release counters=0, candidate cleared.
  - The synchronizer flops also clear to all-ones (no key).
- Synchronizer: row_in passes through 2 flops before use. Scan logic only ever uses the synchronized value.
- Scan sequencing:
  - The dwell counter counts 0..SCAN_DIV-1 for each column index c (0..3); col_out has bit c low.
  - On the last dwell cycle, sample the synchronized rows into that column's hit bits. Then advance c (3 wraps to 0) and reset the dwell counter.
  - One frame is 4*SCAN_DIV cycles. Evaluation happens in the cycle after column 3 is sampled, concurrently with column 0's first dwell cycle.
- Frame classification: empty (0 hits), single (exactly 1 hit, at row r and column c), or multi (2 or more hits).
- Key code map, by row:
  - r0 gives 1, 2, 3, 10.
  - r1 gives 4, 5, 6, 11.
  - r2 gives 7, 8, 9, 12.
  - r3 gives 14, 0, 15, 13.
  - Columns run c0..c3 from left to right.
- Debounce FSM, states IDLE, PRESSING, HELD, RELEASING:
  - IDLE:
    - Single frame: set candidate to the code, set press count to 1, go to PRESSING. If DEBOUNCE_SCANS=1, go straight to accept instead.
    - Empty or multi frame: stay in IDLE.
  - PRESSING:
    - Single frame with the same code: press count increments. When it reaches DEBOUNCE_SCANS, accept.
    - Single frame with a different code: restart with the new candidate, count 1.
    - Empty or multi frame: go to IDLE, count 0.
  - Accept: in the same cycle, button is set to the candidate, bstate goes to 1, key_strobe pulses, and the FSM moves to HELD.
  - HELD:
    - Empty frame: release count set to 1, go to RELEASING. If DEBOUNCE_SCANS=1, release immediately.
    - Single or multi frame (including a different key): stay in HELD. No new press is registered until release.
  - RELEASING:
    - Empty frame: release count increments. At DEBOUNCE_SCANS, set bstate to 0 and go to IDLE.
    - Any non-empty frame: go back to HELD, count 0.
- bstate changes only in frame-evaluation cycles and is registered, so it never glitches.
- button changes only at accept.
- multi is set to 1 in any evaluation cycle whose frame is multi, in all states; otherwise it is 0.
- Counters saturate and never wrap.
- Latency: for a key that is stable from the start of a frame, bstate rises DEBOUNCE_SCANS*4*SCAN_DIV + 1 cycles after that frame starts. Release latency is the same.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=2, frame=16 cycles):
- Reset, then no keys -> col_out cycles 1110, 1101, 1011, 0111 with each pattern held 4 cycles. bstate=0, button=0 throughout.
- Hold row2/col1 (key 8) for 3 frames, then release -> bstate rises at the end of the 2nd frame with a 1-cycle key_strobe, button=8. bstate falls 2 empty frames after release; button stays 8.
- Key 5 pressed for 1 frame, empty frame, then 5 again for 1 frame -> bstate stays 0 and no key_strobe.
- Hold key 1, then press key 9 while 1 is held, then release both -> exactly one acceptance (button=1), 9 ignored. One bstate falling edge after 2 empty frames.
- Hold keys 4 and 6 together for 3 frames -> multi pulses once per frame, bstate stays 0, button unchanged.
- Assert rst while in HELD with key 7 -> next cycle outputs are 1110/0/0/0/0. With key 7 still held, bstate re-rises after 2 full frames.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with frame-based debounce.
// Presents the last accepted key code and a registered, glitch-free held level.
module keypad_scanner #(
  parameter int SCAN_DIV       = 12000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       hwclk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] button,
  output logic       bstate,
  output logic       key_strobe,
  output logic       multi
);

  localparam int             DW         = $clog2(SCAN_DIV);
  localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [4:0]     DEB        = 5'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {IDLE, PRESSING, HELD, RELEASING} state_t;

  logic [3:0]    row_s1, row_s2;
  logic [DW-1:0] dwell;
  logic [1:0]    col_idx;
  logic          eval;
  logic [3:0]    hits [4];

  state_t     state, state_d;
  logic [3:0] cnt, cnt_d;
  logic [3:0] cand, cand_d;
  logic [3:0] button_d;
  logic       bstate_d, strobe_d, multi_d;

  assign col_out = ~(4'b0001 << col_idx);

  always_ff @(posedge hwclk) begin
    if (rst) begin
      row_s1  <= '1;
      row_s2  <= '1;
      dwell   <= '0;
      col_idx <= '0;
      eval    <= 1'b0;
    end else begin
      row_s1 <= row_in;
      row_s2 <= row_s1;
      eval   <= 1'b0;
      if (dwell == DWELL_LAST) begin
        dwell   <= '0;
        col_idx <= col_idx + 2'd1;
        eval    <= (col_idx == 2'd3);
      end else begin
        dwell <= dwell + DW'(1);
      end
    end
  end

  // NOTE: hit bits carry no reset; every column is rewritten before the first evaluation.
  always_ff @(posedge hwclk) begin
    if (dwell == DWELL_LAST) hits[col_idx] <= ~row_s2;
  end

  function automatic logic [3:0] key_code(input logic [3:0] pos);
    case (pos)
      4'd0:  key_code = 4'd1;
      4'd1:  key_code = 4'd2;
      4'd2:  key_code = 4'd3;
      4'd3:  key_code = 4'd10;
      4'd4:  key_code = 4'd4;
      4'd5:  key_code = 4'd5;
      4'd6:  key_code = 4'd6;
      4'd7:  key_code = 4'd11;
      4'd8:  key_code = 4'd7;
      4'd9:  key_code = 4'd8;
      4'd10: key_code = 4'd9;
      4'd11: key_code = 4'd12;
      4'd12: key_code = 4'd14;
      4'd13: key_code = 4'd0;
      4'd14: key_code = 4'd15;
      default: key_code = 4'd13;
    endcase
  endfunction

  logic [15:0] hit_vec;
  logic [4:0]  nhits;
  logic [3:0]  hit_pos, code;
  logic        frame_empty, frame_single, frame_multi;
  logic [4:0]  cnt_inc;

  // hit_vec index is row*4 + column, matching the key-code table order.
  always_comb begin
    hit_vec = '0;
    nhits   = '0;
    hit_pos = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        hit_vec[r*4 + c] = hits[c][r];
    for (int i = 0; i < 16; i++) begin
      if (hit_vec[i]) begin
        nhits   = nhits + 5'd1;
        hit_pos = 4'(i);
      end
    end
  end

  assign frame_empty  = (nhits == 5'd0);
  assign frame_single = (nhits == 5'd1);
  assign frame_multi  = (nhits >= 5'd2);
  assign code         = key_code(hit_pos);
  assign cnt_inc      = {1'b0, cnt} + 5'd1;

  // NOTE: every next-state variable gets its hold value first so no latch is inferred.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    cand_d   = cand;
    button_d = button;
    bstate_d = bstate;
    strobe_d = 1'b0;
    multi_d  = 1'b0;
    if (eval) begin
      multi_d = frame_multi;
      case (state)
        IDLE: if (frame_single) begin
          cand_d = code;
          if (DEB == 5'd1) begin
            button_d = code;
            bstate_d = 1'b1;
            strobe_d = 1'b1;
            cnt_d    = '0;
            state_d  = HELD;
          end else begin
            cnt_d   = 4'd1;
            state_d = PRESSING;
          end
        end
        PRESSING: begin
          if (frame_single && code == cand) begin
            if (cnt_inc >= DEB) begin
              button_d = cand;
              bstate_d = 1'b1;
              strobe_d = 1'b1;
              cnt_d    = '0;
              state_d  = HELD;
            end else begin
              cnt_d = cnt_inc[3:0];
            end
          end else if (frame_single) begin
            cand_d = code;
            cnt_d  = 4'd1;
          end else begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
        HELD: if (frame_empty) begin
          if (DEB == 5'd1) begin
            bstate_d = 1'b0;
            cnt_d    = '0;
            state_d  = IDLE;
          end else begin
            cnt_d   = 4'd1;
            state_d = RELEASING;
          end
        end
        RELEASING: begin
          if (!frame_empty) begin
            cnt_d   = '0;
            state_d = HELD;
          end else if (cnt_inc >= DEB) begin
            bstate_d = 1'b0;
            cnt_d    = '0;
            state_d  = IDLE;
          end else begin
            cnt_d = cnt_inc[3:0];
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge hwclk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      cand       <= '0;
      button     <= '0;
      bstate     <= 1'b0;
      key_strobe <= 1'b0;
      multi      <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      cand       <= cand_d;
      button     <= button_d;
      bstate     <= bstate_d;
      key_strobe <= strobe_d;
      multi      <= multi_d;
    end
  end

endmodule
